// File: rtl/rr_grant_ctrl_pkg.sv
// Shared definitions for the round-robin grant controller: FSM encodings,
// gap counter width and the clog2 helper used to size the owner index.
package rr_grant_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int GAP_W = 4;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// Combinational round-robin picker: rotates a doubled request vector by ptr
// and priority-encodes the lowest set bit, so the search starts at ptr and wraps.
module rr_pick
  import rr_grant_ctrl_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IW    = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [PORTS-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [2*PORTS-1:0] dbl;
  logic [PORTS-1:0]   rot;
  logic [IW:0]        off;
  logic [IW:0]        sum;

  always_comb begin
    dbl = {req, req};
    rot = PORTS'(dbl >> ptr);
    off = '0;
    any = 1'b0;
    // Descending scan so the lowest rotated offset (closest to ptr) wins.
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = (IW + 1)'(i);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW + 1)'(PORTS)) sum = sum - (IW + 1)'(PORTS);
    idx  = sum[IW-1:0];
    pick = '0;
    if (any) pick[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registered one-hot grant held until the owner
// releases (req drop or ack pulse), followed by a programmable idle gap.
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int GAP   = 1,
  parameter int IW    = clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] ack,
  output logic [PORTS-1:0] grant,
  output logic             busy,
  output logic [IW-1:0]    owner,
  output logic [1:0]       state_dbg
);

  // Handshake: a port asserts req (level) and keeps it until done; the owner
  // releases either by dropping req or by a one-cycle ack pulse. Both in the
  // same cycle count as one release; ack from non-owners is ignored.

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

  state_e             state, state_d;
  logic [PORTS-1:0]   grant_d;
  logic [IW-1:0]      owner_d;
  logic [IW-1:0]      ptr, ptr_d;
  logic [GAP_W-1:0]   cnt, cnt_d;
  logic [PORTS-1:0]   pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(.PORTS(PORTS), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      owner <= owner_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    ptr_d   = ptr;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner] || ack[owner]) begin
          grant_d = '0;
          ptr_d   = (owner == IW'(PORTS - 1)) ? '0 : owner + IW'(1);
          cnt_d   = GAP_LOAD;
          state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_d = ST_IDLE;
        else           cnt_d   = cnt - GAP_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: reset, round-robin order, non-owner ack,
// simultaneous release, gap lengths for GAP=0/1/3 and reset mid-grant.
module tb_rr_grant_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] req,    ack,    grant;
  logic [3:0] req_g0, ack_g0, grant_g0;
  logic [3:0] req_g3, ack_g3, grant_g3;
  logic       busy, busy_g0, busy_g3;
  logic [1:0] owner, owner_g0, owner_g3;
  logic [1:0] st, st_g0, st_g3;

  rr_grant_ctrl #(.PORTS(4), .GAP(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .grant(grant),
    .busy(busy), .owner(owner), .state_dbg(st)
  );
  rr_grant_ctrl #(.PORTS(4), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .req(req_g0), .ack(ack_g0), .grant(grant_g0),
    .busy(busy_g0), .owner(owner_g0), .state_dbg(st_g0)
  );
  rr_grant_ctrl #(.PORTS(4), .GAP(3)) u_dut_g3 (
    .clk(clk), .rst(rst), .req(req_g3), .ack(ack_g3), .grant(grant_g3),
    .busy(busy_g3), .owner(owner_g3), .state_dbg(st_g3)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant === 4'b0000 && n < 16) begin
      cyc();
      n++;
    end
    chk("grant_timeout", 32'(n < 16), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  int n, n0, n3;

  initial begin
    rst = 1'b1;
    req = '0;    ack = '0;
    req_g0 = '0; ack_g0 = '0;
    req_g3 = '0; ack_g3 = '0;
    do_reset();

    // reset values
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_state", st,    2'd0);

    // single request, one-cycle grant latency, release then one gap cycle
    req = 4'b0001;
    cyc();
    chk("single_grant", grant, 4'b0001);
    chk("single_owner", owner, 2'd0);
    chk("single_busy",  busy,  1'b1);
    req = 4'b0000;
    cyc();
    chk("single_release", grant, 4'b0000);
    chk("single_gap_busy", busy, 1'b1);
    cyc();
    chk("single_idle_busy", busy, 1'b0);

    // round robin from fresh reset: 0,1,2,3,0 with ack on first grant cycle
    do_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(4'b0001 << (k % 4));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      exp_g = exp_q.pop_front();
      chk("rr_order", grant, exp_g);
      chk("rr_zero_cycles", n, (k == 0) ? 1 : 2);
      if (k < 4) begin
        ack = grant;
        cyc();
        ack = '0;
        chk("rr_release", grant, 4'b0000);
      end
    end

    // walk ownership to port 2, then non-owner ack must be ignored
    ack = grant; cyc(); ack = '0;
    wait_grant(n);
    chk("walk_port1", grant, 4'b0010);
    ack = grant; cyc(); ack = '0;
    wait_grant(n);
    chk("walk_port2", grant, 4'b0100);
    ack = 4'b0001;
    cyc();
    ack = '0;
    chk("nonowner_grant", grant, 4'b0100);
    chk("nonowner_owner", owner, 2'd2);
    cyc();
    chk("nonowner_hold", grant, 4'b0100);
    ack = 4'b0100; cyc(); ack = '0;
    wait_grant(n);
    chk("nonowner_ptr_next", grant, 4'b1000);

    // simultaneous req drop and ack from owner 1, port 3 pending
    req = 4'b1010;
    ack = 4'b1000; cyc(); ack = '0;
    wait_grant(n);
    chk("simul_setup", grant, 4'b0010);
    req = 4'b1000;
    ack = 4'b0010;
    cyc();
    ack = '0;
    chk("simul_release", grant, 4'b0000);
    chk("simul_owner_hold", owner, 2'd1);
    chk("simul_busy", busy, 1'b1);
    wait_grant(n);
    chk("simul_next", grant, 4'b1000);
    chk("simul_zero_cycles", n, 2);
    chk("simul_owner_new", owner, 2'd3);
    req = '0;
    cyc(); cyc(); cyc();
    chk("simul_idle", busy, 1'b0);

    // reset mid-grant
    req = 4'b0010;
    cyc();
    chk("midrst_grant", grant, 4'b0010);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_grant0", grant, 4'b0000);
    chk("midrst_busy",   busy,  1'b0);
    chk("midrst_owner",  owner, 2'd0);
    chk("midrst_state",  st,    2'd0);
    req = 4'b0011;
    cyc();
    chk("midrst_ptr0", grant, 4'b0001);
    req = '0;

    // GAP=0 and GAP=3: zero-grant cycles between back-to-back grants
    req_g0 = 4'b0011;
    req_g3 = 4'b0011;
    cyc();
    chk("g0_first", grant_g0, 4'b0001);
    chk("g3_first", grant_g3, 4'b0001);
    ack_g0 = 4'b0001;
    ack_g3 = 4'b0001;
    cyc();
    ack_g0 = '0;
    ack_g3 = '0;
    chk("g0_release", grant_g0, 4'b0000);
    chk("g3_release", grant_g3, 4'b0000);
    n0 = 0;
    n3 = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 2) chk("g3_gap_busy", busy_g3, 1'b1);
      if (n0 == 0 && grant_g0 !== 4'b0000) n0 = i;
      if (n3 == 0 && grant_g3 !== 4'b0000) n3 = i;
    end
    chk("g0_zero_cycles", n0, 1);
    chk("g3_zero_cycles", n3, 4);
    chk("g0_next", grant_g0, 4'b0010);
    chk("g3_next", grant_g3, 4'b0010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
